// File: rtl/cache_opr_seq.sv
// Serial cache sub-operation sequencer: optional launch delay, per-stage opr_done
// handshakes with timeout, abort, and an independent valid delay line.
module cache_opr_seq #(
  parameter int NUM_OPS   = 4,
  parameter int STG_W     = $clog2(NUM_OPS),
  parameter int START_DLY = 4,
  parameter int TIMEOUT   = 256,
  parameter int CNT_W     = 9,
  parameter int VALID_DLY = 2
) (
  input  logic                 clk_i,
  input  logic                 rstb_i,
  input  logic                 valid_i,
  input  logic                 abort_i,
  input  logic [NUM_OPS-1:0]   opr_done_i,
  output logic [VALID_DLY-1:0] valid_dly_o,
  output logic                 busy_o,
  output logic [NUM_OPS-1:0]   opr_en_o,
  output logic [NUM_OPS-1:0]   opr_pulse_o,
  output logic [STG_W-1:0]     cur_stage_o,
  output logic                 seq_done_o,
  output logic                 seq_timeout_o
);

  typedef enum logic [1:0] {IDLE, WAIT, RUN, FIN} state_e;

  localparam logic [CNT_W-1:0] START_LAST = (START_DLY > 0) ? CNT_W'(START_DLY - 1) : '0;
  localparam logic [CNT_W-1:0] TO_LAST    = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [STG_W-1:0] LAST_STG   = STG_W'(NUM_OPS - 1);

  state_e               state_q, state_d;
  logic [STG_W-1:0]     stage_q, stage_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 timeout_d;
  logic [NUM_OPS-1:0]   en_d, en_q, en_prev_q;
  logic                 busy_q, done_q, timeout_q;
  logic [VALID_DLY-1:0] vdly_q;

  // Abort outranks everything; opr_done outranks the timeout in the same cycle.
  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    if (abort_i) begin
      state_d = IDLE;
      stage_d = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d   = '0;
          stage_d = '0;
          if (valid_i) state_d = (START_DLY == 0) ? RUN : WAIT;
        end
        WAIT: begin
          if (cnt_q == START_LAST) begin
            state_d = RUN;
            stage_d = '0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        RUN: begin
          if (opr_done_i[stage_q]) begin
            cnt_d = '0;
            if (stage_q == LAST_STG) begin
              state_d = FIN;
              stage_d = '0;
            end else begin
              stage_d = stage_q + STG_W'(1);
            end
          end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
            state_d   = IDLE;
            stage_d   = '0;
            cnt_d     = '0;
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        FIN: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
        default: begin
          state_d = IDLE;
          stage_d = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    en_d = '0;
    if (state_d == RUN) begin
      for (int i = 0; i < NUM_OPS; i++) en_d[i] = (STG_W'(i) <= stage_d);
    end
  end

  // Outputs are registered from the next state so they line up with the state.
  always_ff @(posedge clk_i) begin
    if (!rstb_i) begin
      state_q   <= IDLE;
      stage_q   <= '0;
      cnt_q     <= '0;
      en_q      <= '0;
      en_prev_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      vdly_q    <= '0;
    end else begin
      state_q   <= state_d;
      stage_q   <= stage_d;
      cnt_q     <= cnt_d;
      en_q      <= en_d;
      en_prev_q <= en_q;
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_d == FIN);
      timeout_q <= timeout_d;
      vdly_q    <= VALID_DLY'({vdly_q, valid_i});
    end
  end

  assign valid_dly_o   = vdly_q;
  assign busy_o        = busy_q;
  assign opr_en_o      = en_q;
  assign opr_pulse_o   = en_q & ~en_prev_q;
  assign cur_stage_o   = stage_q;
  assign seq_done_o    = done_q;
  assign seq_timeout_o = timeout_q;

endmodule

// File: tb/tb_cache_opr_seq.sv
// Directed bench for cache_opr_seq: two instances (launch delay 4 / timeout 8,
// and zero delay / no timeout), expected outputs queued per step and popped after the edge.
module tb_cache_opr_seq;

  logic clk = 1'b0;
  logic rstb = 1'b0;
  logic vA = 1'b0, aA = 1'b0, vB = 1'b0, aB = 1'b0;
  logic [3:0] dA = '0, dB = '0;

  logic [1:0] vdlyA, vdlyB, stageA, stageB;
  logic [3:0] enA, enB, pulseA, pulseB;
  logic busyA, busyB, doneA, doneB, toA, toB;

  int checks = 0;
  int passes = 0;

  typedef struct {
    string tag;
    int sel;
    logic [3:0] en;
    logic [3:0] pulse;
    logic [1:0] stage;
    logic [1:0] vdly;
    logic busy;
    logic done;
    logic to;
  } exp_t;

  exp_t sbQ[$];
  logic [1:0] vhist[2] = '{2'b00, 2'b00};
  logic [3:0] prevEn[2] = '{4'h0, 4'h0};

  cache_opr_seq #(.NUM_OPS(4), .START_DLY(4), .TIMEOUT(8), .CNT_W(9), .VALID_DLY(2)) u_dutA (
    .clk_i(clk), .rstb_i(rstb), .valid_i(vA), .abort_i(aA), .opr_done_i(dA),
    .valid_dly_o(vdlyA), .busy_o(busyA), .opr_en_o(enA), .opr_pulse_o(pulseA),
    .cur_stage_o(stageA), .seq_done_o(doneA), .seq_timeout_o(toA));

  cache_opr_seq #(.NUM_OPS(4), .START_DLY(0), .TIMEOUT(0), .CNT_W(9), .VALID_DLY(2)) u_dutB (
    .clk_i(clk), .rstb_i(rstb), .valid_i(vB), .abort_i(aB), .opr_done_i(dB),
    .valid_dly_o(vdlyB), .busy_o(busyB), .opr_en_o(enB), .opr_pulse_o(pulseB),
    .cur_stage_o(stageB), .seq_done_o(doneB), .seq_timeout_o(toB));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [3:0] therm(input int k);
    return 4'((1 << (k + 1)) - 1);
  endfunction

  function automatic logic [3:0] onehot(input int k);
    return 4'(1 << k);
  endfunction

  task automatic chk(input string tag, input string nm, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("[TB] FAIL %s.%s observed=%0h expected=%0h", tag, nm, obs, expv);
  endtask

  task automatic checkOutput();
    exp_t e;
    logic [3:0] oEn, oPulse;
    logic [1:0] oStage, oVdly;
    logic oBusy, oDone, oTo;
    e = sbQ.pop_front();
    if (e.sel == 0) begin
      oEn = enA; oPulse = pulseA; oStage = stageA; oVdly = vdlyA;
      oBusy = busyA; oDone = doneA; oTo = toA;
    end else begin
      oEn = enB; oPulse = pulseB; oStage = stageB; oVdly = vdlyB;
      oBusy = busyB; oDone = doneB; oTo = toB;
    end
    chk(e.tag, "opr_en", 8'(oEn), 8'(e.en));
    chk(e.tag, "opr_pulse", 8'(oPulse), 8'(e.pulse));
    chk(e.tag, "cur_stage", 8'(oStage), 8'(e.stage));
    chk(e.tag, "valid_dly", 8'(oVdly), 8'(e.vdly));
    chk(e.tag, "busy", 8'(oBusy), 8'(e.busy));
    chk(e.tag, "seq_done", 8'(oDone), 8'(e.done));
    chk(e.tag, "seq_timeout", 8'(oTo), 8'(e.to));
  endtask

  // Drives one cycle of inputs to the selected instance and queues its outputs after the edge.
  task automatic applyStimulus(input string tag, input int sel, input logic v, input logic a,
                               input logic [3:0] d, input logic [3:0] en, input logic busy,
                               input logic done, input logic to);
    exp_t e;
    @(negedge clk);
    if (sel == 0) begin
      vA = v; aA = a; dA = d; vB = 1'b0; aB = 1'b0; dB = '0;
    end else begin
      vB = v; aB = a; dB = d; vA = 1'b0; aA = 1'b0; dA = '0;
    end
    for (int s = 0; s < 2; s++) begin
      if (!rstb) begin
        vhist[s]  = '0;
        prevEn[s] = '0;
      end else begin
        vhist[s] = {vhist[s][0], (s == sel) ? v : 1'b0};
      end
    end
    e.tag   = tag;
    e.sel   = sel;
    e.en    = en;
    e.pulse = en & ~prevEn[sel];
    prevEn[sel] = en;
    e.stage = (en == 4'h0) ? 2'd0 : 2'($countones(en) - 1);
    e.vdly  = vhist[sel];
    e.busy  = busy;
    e.done  = done;
    e.to    = to;
    sbQ.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  // Accepts a request on instance A and completes stages 0..upTo-1 (3 cycles each),
  // leaving it in the first cycle of stage upTo (or FIN when upTo is 4).
  task automatic startSeqA(input string tag, input logic noise, input int upTo);
    applyStimulus(tag, 0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      applyStimulus(tag, 0, noise, 1'b0, noise ? 4'hF : 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    applyStimulus(tag, 0, noise, 1'b0, noise ? 4'hF : 4'h0, therm(0), 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < upTo; k++) begin
      for (int j = 0; j < 2; j++)
        applyStimulus(tag, 0, noise, 1'b0, noise ? ~onehot(k) : 4'h0, therm(k), 1'b1, 1'b0, 1'b0);
      applyStimulus(tag, 0, noise, 1'b0, onehot(k), (k == 3) ? 4'h0 : therm(k + 1),
                    1'b1, (k == 3), 1'b0);
    end
  endtask

  initial begin
    rstb = 1'b0;
    applyStimulus("resetA", 0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus("resetB", 1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    rstb = 1'b1;
    applyStimulus("idleA", 0, 1'b0, 1'b0, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0);

    startSeqA("normal", 1'b0, 4);
    applyStimulus("normal", 0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus("normal", 0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);

    startSeqA("ignore", 1'b1, 4);
    applyStimulus("ignore", 0, 1'b1, 1'b0, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus("ignore", 0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus("ignore", 0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);

    startSeqA("timeout", 1'b0, 1);
    for (int i = 0; i < 7; i++)
      applyStimulus("timeout", 0, 1'b0, 1'b0, 4'h0, therm(1), 1'b1, 1'b0, 1'b0);
    applyStimulus("timeout", 0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    applyStimulus("timeout", 0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);

    startSeqA("abortLast", 1'b0, 3);
    applyStimulus("abortLast", 0, 1'b0, 1'b0, 4'h0, therm(3), 1'b1, 1'b0, 1'b0);
    applyStimulus("abortLast", 0, 1'b0, 1'b1, 4'h8, 4'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus("abortLast", 0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);

    applyStimulus("abortWait", 0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    applyStimulus("abortWait", 0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    applyStimulus("abortWait", 0, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus("abortWait", 0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);

    startSeqA("rstRun", 1'b0, 2);
    applyStimulus("rstRun", 0, 1'b1, 1'b0, 4'h0, therm(2), 1'b1, 1'b0, 1'b0);
    rstb = 1'b0;
    applyStimulus("rstRun", 0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    rstb = 1'b1;
    startSeqA("restart", 1'b0, 4);
    applyStimulus("restart", 0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);

    applyStimulus("zeroDly", 1, 1'b1, 1'b0, 4'hF, therm(0), 1'b1, 1'b0, 1'b0);
    applyStimulus("zeroDly", 1, 1'b1, 1'b0, 4'hF, therm(1), 1'b1, 1'b0, 1'b0);
    applyStimulus("zeroDly", 1, 1'b1, 1'b0, 4'hF, therm(2), 1'b1, 1'b0, 1'b0);
    applyStimulus("zeroDly", 1, 1'b1, 1'b0, 4'hF, therm(3), 1'b1, 1'b0, 1'b0);
    applyStimulus("zeroDly", 1, 1'b1, 1'b0, 4'hF, 4'h0, 1'b1, 1'b1, 1'b0);
    applyStimulus("zeroDly", 1, 1'b1, 1'b0, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus("reaccept", 1, 1'b1, 1'b0, 4'h0, therm(0), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++)
      applyStimulus("noTimeout", 1, 1'b0, 1'b0, 4'h0, therm(0), 1'b1, 1'b0, 1'b0);
    applyStimulus("abortRun", 1, 1'b0, 1'b1, 4'h1, 4'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus("abortRun", 1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/cache_opr_seq.md
# cache_opr_seq

Parametrised cache operation sequencer: on a `valid` request it runs `NUM_OPS` cache sub-operations strictly in series and supersedes the fixed two-stage, counter-thresholded controller. Stages advance on per-stage `opr_done` handshakes rather than fixed counts. The block adds a programmable launch delay, a per-stage timeout, an abort, and a parametrised `valid` delay line. It sits between the cache request front-end and the tag/data/writeback operation blocks.

## Interface
- `NUM_OPS`, 4: number of serial stages; legal range 2..16.
- `STG_W`, `$clog2(NUM_OPS)`: stage index width.
- `START_DLY`, 4: cycles from request acceptance to stage 0 enable; 0 is legal.
- `TIMEOUT`, 256: maximum cycles per stage; 0 disables the timeout.
- `CNT_W`, 9: shared counter width; must hold `max(START_DLY, TIMEOUT)`.
- `VALID_DLY`, 2: depth of the `valid` delay line, at least 1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rstb` in 1: synchronous, active-low reset.
- `valid` in 1: request strobe, sampled only in IDLE.
- `abort` in 1: cancels any sequence in progress.
- `opr_done` in NUM_OPS: bit k is stage k completion; only the active stage's bit is observed.
- `valid_dly` out VALID_DLY: bit i is `valid` delayed by i+1 cycles.
- `busy` out 1: high from acceptance through the FIN cycle.
- `opr_en` out NUM_OPS: thermometer enable; bits 0..k are high while stage k is active.
- `opr_pulse` out NUM_OPS: one-cycle pulse in the first cycle `opr_en[k]` is high.
- `cur_stage` out STG_W: index of the active stage; 0 when not in RUN.
- `seq_done` out 1: one-cycle pulse on completion of the last stage.
- `seq_timeout` out 1: one-cycle pulse when a stage times out.

## Operation
- Reset, with `rstb` low at a clock edge:
  - State goes to IDLE and all counters clear.
  - Every output is 0, including all `valid_dly` taps.
- States are IDLE, WAIT, RUN and FIN.
- IDLE:
  - With `valid`=1 and `abort`=0, go to WAIT; if `START_DLY`=0, go directly to RUN at stage 0.
  - Counter clears on entry.
- WAIT:
  - Counter increments every cycle.
  - When counter == `START_DLY-1`, go to RUN with stage=0 and counter=0.
- RUN, stage k:
  - `opr_en` = ones in bits 0..k; `cur_stage`=k.
  - Counter counts cycles spent in the stage.
  - If `opr_done[k]`=1 and k < NUM_OPS-1: advance to stage k+1 and clear the counter.
  - If `opr_done[k]`=1 and k = NUM_OPS-1: go to FIN.
  - Else, if `TIMEOUT`≠0 and counter == `TIMEOUT-1`: go to IDLE and assert `seq_timeout` in the next cycle.
- FIN:
  - Lasts exactly one cycle with `seq_done`=1, `busy`=1 and `opr_en`=0.
  - Next state is IDLE.
- Priority, highest first: `rstb`, `abort`, `opr_done`, timeout, `valid`.
- `abort`=1 in any state:
  - Next state is IDLE with `opr_en`, `busy` and `cur_stage` cleared.
  - No `seq_done` or `seq_timeout` pulse.
- `valid` outside IDLE, including in FIN, is ignored: no queueing and no error.
- `opr_done` bits other than the active stage's are ignored, as are all `opr_done` bits outside RUN.
- `opr_pulse[k]` = `opr_en[k]` & ~`opr_en[k]` registered one cycle; `opr_pulse` is only ever one-hot.
- The `valid_dly` line runs independently of the state machine.
- All state elements are registered; `opr_pulse` is the only combinational output.

## Timing
- `valid` sampled at edge T while IDLE:
  - `busy`=1 from T+1.
  - With `START_DLY`=D≥1: `opr_en[0]` and `opr_pulse[0]` high at T+1+D.
  - With D=0: `opr_en[0]` high at T+1.
- `opr_done[k]` sampled at edge E:
  - Stage k+1 is active from E+1.
  - For the last stage, FIN (`seq_done`) is at E+1 and IDLE at E+2.
  - Back-to-back acceptance is earliest at E+2.
- Minimum per-stage occupancy is 1 cycle (`opr_done` high in the first cycle).
- Timeout is signalled TIMEOUT cycles after stage entry; `seq_timeout` and IDLE coincide.
- Abort at edge A: all outputs are 0 at A+1, except `valid_dly`.
- `valid_dly[i]` at cycle t equals `valid` at t-1-i.

## Test plan
- Reset mid-RUN at stage 2 (NUM_OPS=4, START_DLY=4) -> next cycle all outputs 0 and IDLE; a new `valid` restarts from WAIT.
- `valid` at T=10 with `opr_done[k]` returned 3 cycles after each `opr_pulse[k]` -> `opr_en`=0001 at 15, 0011 at 18, 0111 at 21, 1111 at 24, `seq_done` at 27, `busy` low at 28.
- START_DLY=0, `opr_done` held at all ones -> stages advance every cycle, `seq_done` at T+5; a `valid` held high re-accepts at T+6.
- TIMEOUT=8 with stage 1 never done -> `seq_timeout`=1 and `opr_en`=0 exactly 8 cycles after `opr_pulse[1]`; `seq_done` never asserts.
- `abort` during WAIT, and separately together with `opr_done[3]` in the last stage -> IDLE next cycle, no `seq_done`.
- `valid` asserted during RUN and FIN, and `opr_done[2]` during stage 0 -> both ignored; the sequence timing is unchanged.
